sva_stim_pattern_gen: RTL and testbench

- Sequencer that drives a sampled signal with programmed runs of "change" and "hold", so that $changed/$stable checks and covers in testbenches get known stimulus.
- A bench or CPU model pushes run commands through a valid/ready port. The block sequences them into a registered data output.
- It also keeps golden counts of how many sampled edges were changed and how many were stable. Checker cover counts can be compared against these counts directly.

---
 rtl/sva_stim_pkg.sv | 23 ++
 rtl/sva_stim_pattern_gen_if.sv | 16 +
 rtl/sva_stim_cmd_fifo.sv | 67 ++++++
 rtl/sva_stim_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_sva_stim_pattern_gen.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sva_stim_pkg.sv
// Shared types for the $changed/$stable stimulus sequencer: FSM states,
// default widths and the queued run command.
package sva_stim_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_LEN_W = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_DEPTH = 4;

    typedef logic [DEF_WIDTH-1:0] value_t;
    typedef logic [DEF_LEN_W-1:0] len_t;

    typedef struct packed {
        value_t value;
        len_t   len;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sva_stim_pattern_gen_if.sv
// Run-command port of the stimulus sequencer: valid/ready plus the value and
// extra-hold length of one run.
interface sva_stim_pattern_gen_if
    import sva_stim_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_value;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_value, output cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_value, input cmd_len, output cmd_ready);
endinterface

// File: rtl/sva_stim_cmd_fifo.sv
// Small synchronous FIFO of run commands with registered full/empty flags;
// the head entry is read straight from the storage array.
module sva_stim_cmd_fifo
    import sva_stim_pkg::*;
#(
    parameter type T     = cmd_t,
    parameter int  DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_PTR = {{(AW-1){1'b0}}, 1'b1};

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop)
            count_n = count + ONE_CNT;
        else if (!do_push && do_pop)
            count_n = count - ONE_CNT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + ONE_PTR;
            if (do_pop)
                rd_ptr <= rd_ptr + ONE_PTR;
            count <= count_n;
            full  <= (count_n == FULL_CNT);
            empty <= (count_n == '0);
        end
    end

    // Storage holds no control state, so it is left out of the reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sva_stim_pattern_gen.sv
// Plays queued change/hold runs onto a registered data signal and keeps golden
// counts of changed and stable sampled edges for checker cover comparison.
module sva_stim_pattern_gen
    import sva_stim_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    sva_stim_pattern_gen_if.slave  cmd_if,
    input  logic                   count_en,
    input  logic                   clear,
    output logic [WIDTH-1:0]       data,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       exp_changed,
    output logic [CNT_W-1:0]       exp_stable
);
    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic [LEN_W-1:0] len;
    } run_cmd_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    run_cmd_t         push_cmd;
    run_cmd_t         head_cmd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    state_e           state_q, state_n;
    logic [LEN_W-1:0] remain_q, remain_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] chg_q;
    logic [CNT_W-1:0] stb_q;

    assign push_cmd.value  = cmd_if.cmd_value;
    assign push_cmd.len    = cmd_if.cmd_len;
    assign cmd_if.cmd_ready = !fifo_full;

    sva_stim_cmd_fifo #(
        .T     (run_cmd_t),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_if.cmd_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A run ending with more work queued loads the next one on the same edge.
    always_comb begin
        state_n  = state_q;
        remain_n = remain_q;
        data_n   = data_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_n   = head_cmd.value;
                    remain_n = head_cmd.len;
                    busy_n   = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (remain_q != '0) begin
                    remain_n = remain_q - LEN_W'(1);
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_n   = head_cmd.value;
                    remain_n = head_cmd.len;
                end else begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            remain_q <= remain_n;
            data_q   <= data_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // Counting looks at data as it was before this edge, like $past sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            chg_q  <= '0;
            stb_q  <= '0;
        end else begin
            if (count_en)
                prev_q <= data_q;
            if (clear) begin
                chg_q <= '0;
                stb_q <= '0;
            end else if (count_en) begin
                if (data_q != prev_q)
                    chg_q <= sat_inc(chg_q);
                else
                    stb_q <= sat_inc(stb_q);
            end
        end
    end

    assign data        = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign exp_changed = chg_q;
    assign exp_stable  = stb_q;

endmodule

// File: tb/tb_sva_stim_pattern_gen.sv
// Randomised and directed bench for sva_stim_pattern_gen with a run-queue
// reference model and a negedge scoreboard monitor.
module tb_sva_stim_pattern_gen;
    localparam int W  = 1;
    localparam int LW = 8;
    localparam int CW = 16;
    localparam int D  = 4;
    localparam int SAT_CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic count_en = 1'b0;
    logic clear = 1'b0;

    logic [W-1:0]      data;
    logic              busy, done;
    logic [CW-1:0]     exp_changed, exp_stable;
    logic [W-1:0]      s_data;
    logic              s_busy, s_done;
    logic [SAT_CW-1:0] s_changed, s_stable;

    sva_stim_pattern_gen_if #(.WIDTH(W), .LEN_W(LW)) cmd_if ();
    sva_stim_pattern_gen_if #(.WIDTH(W), .LEN_W(LW)) sat_if ();

    assign sat_if.cmd_valid = 1'b0;
    assign sat_if.cmd_value = '0;
    assign sat_if.cmd_len   = '0;

    sva_stim_pattern_gen #(.WIDTH(W), .LEN_W(LW), .CNT_W(CW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .cmd_if(cmd_if), .count_en(count_en), .clear(clear),
        .data(data), .busy(busy), .done(done),
        .exp_changed(exp_changed), .exp_stable(exp_stable)
    );

    sva_stim_pattern_gen #(.WIDTH(W), .LEN_W(LW), .CNT_W(SAT_CW), .DEPTH(D)) sat_dut (
        .clk(clk), .rst(rst), .cmd_if(sat_if), .count_en(count_en), .clear(clear),
        .data(s_data), .busy(s_busy), .done(s_done),
        .exp_changed(s_changed), .exp_stable(s_stable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] value;
        int           len;
        int           acc;
    } run_t;

    run_t         rq[$];
    int           ec = 0;
    int           head_used = 0;
    logic         exp_done = 1'b0;
    logic [W-1:0] last_data = '0;
    logic [W-1:0] cur_exp_data = '0;
    logic [W-1:0] prev_m = '0;
    int           m_chg = 0, m_stb = 0, s_chg = 0, s_stb = 0;
    bit           mon_en = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;

    function automatic int sat_add(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each active edge: accepted commands, golden counts.
    always @(posedge clk) begin
        ec++;
        if (rst) begin
            rq.delete();
            head_used = 0;
            exp_done = 1'b0;
            last_data = '0;
            cur_exp_data = '0;
            prev_m = '0;
            m_chg = 0; m_stb = 0; s_chg = 0; s_stb = 0;
            mon_en = 1'b1;
        end else begin
            if (cmd_if.cmd_valid && cmd_if.cmd_ready)
                rq.push_back('{value: cmd_if.cmd_value, len: int'(cmd_if.cmd_len), acc: ec});
            if (clear) begin
                m_chg = 0; m_stb = 0; s_chg = 0; s_stb = 0;
            end else if (count_en) begin
                if (cur_exp_data != prev_m) m_chg = sat_add(m_chg, (1 << CW) - 1);
                else                        m_stb = sat_add(m_stb, (1 << CW) - 1);
                s_stb = sat_add(s_stb, (1 << SAT_CW) - 1);
            end
            if (count_en)
                prev_m = cur_exp_data;
        end
    end

    // Scoreboard monitor: the head run is on data once it was accepted before the last edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            int   occ;
            exp_busy = (rq.size() > 0) && (rq[0].acc < ec);
            occ = rq.size() - (exp_busy ? 1 : 0);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(occ < D));
            cur_exp_data = exp_busy ? rq[0].value : last_data;
            chk("data", 32'(data), 32'(cur_exp_data));
            chk("exp_changed", 32'(exp_changed), 32'(m_chg));
            chk("exp_stable", 32'(exp_stable), 32'(m_stb));
            chk("sat_changed", 32'(s_changed), 32'(s_chg));
            chk("sat_stable", 32'(s_stable), 32'(s_stb));
            chk("sat_idle", {29'd0, s_busy, s_done, s_data}, {29'd0, 1'b0, 1'b0, 1'b0});
            chk("sat_ready", 32'(sat_if.cmd_ready), 32'd1);
            if (exp_busy) begin
                if (head_used == rq[0].len) begin
                    exp_done = (rq.size() == 1);
                    last_data = rq[0].value;
                    void'(rq.pop_front());
                    head_used = 0;
                end else begin
                    head_used++;
                    exp_done = 1'b0;
                end
            end else begin
                exp_done = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [W-1:0] v, input int len);
        int guard;
        guard = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_value = v;
        cmd_if.cmd_len   = LW'(len);
        while (!cmd_if.cmd_ready && guard < 300) begin
            step(1);
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: cmd_ready stuck at %0b, required 1", cmd_if.cmd_ready);
        end
        step(1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_value = '0;
        cmd_if.cmd_len   = '0;
        #1 rst = 1'b1;
        step(3);
        rst = 1'b0;

        // Idle stability: five counted edges with no commands.
        count_en = 1'b1;
        step(5);
        chk("idle_stable5", 32'(exp_stable), 32'd5);
        chk("idle_changed0", 32'(exp_changed), 32'd0);

        // Toggle train 1,0,1,1,1.
        push(1'b1, 0);
        push(1'b0, 0);
        push(1'b1, 2);
        step(8);
        chk("toggle_changed3", 32'(exp_changed), 32'd3);
        chk("sat_stable7", 32'(s_stable), 32'd7);

        // clear beats the changed edge; the next stable edge counts 1.
        push(1'b0, 0);
        step(1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear_changed", 32'(exp_changed), 32'd0);
        chk("clear_stable", 32'(exp_stable), 32'd0);
        step(1);
        chk("after_clear_stable", 32'(exp_stable), 32'd1);

        // Backpressure: one long run plus four queued fills the FIFO.
        push(1'b1, 10);
        push(1'b0, 1);
        push(1'b1, 0);
        push(1'b0, 2);
        push(1'b1, 1);
        chk("full_ready0", 32'(cmd_if.cmd_ready), 32'd0);
        push(1'b0, 0);
        step(25);

        // Reset in the middle of a run with two queued commands.
        push(1'b1, 5);
        push(1'b0, 1);
        push(1'b1, 0);
        step(2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        step(10);

        // Randomised runs, counting enables and clears.
        for (int i = 0; i < 300; i++) begin
            count_en = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) != 0)
                push(W'($urandom_range(0, 1)), $urandom_range(0, 3));
            else
                step(1);
        end
        clear = 1'b0;
        count_en = 1'b1;
        step(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
